// File: rtl/fb_pkg.sv
// fb_pkg: shared framebuffer geometry, widths and scheduler state type.
package fb_pkg;
    localparam int H_ACTIVE     = 1280;
    localparam int V_ACTIVE     = 720;
    localparam int SRC_W        = H_ACTIVE / 2;
    localparam int SRC_DEPTH    = SRC_W * (V_ACTIVE / 2);
    localparam int ADDR_W       = 18;
    localparam int PIX_W        = 16;
    localparam int BRAM_LATENCY = 2;
    localparam int PIPE_L       = BRAM_LATENCY + 2;
    typedef enum logic {SYNC, RUN} fb_sched_state_t;
endpackage

// File: rtl/fb_addr_gen.sv
// fb_addr_gen: maps video counts to the half-resolution source address plus active/parity flags.
module fb_addr_gen import fb_pkg::*; (
    input  logic [10:0]       hcount_i,
    input  logic [9:0]        vcount_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              active_o,
    output logic              odd_o
);
    logic [9:0] sx;
    logic [8:0] sy;
    always_comb begin
        sx = hcount_i[10:1];
        sy = vcount_i[9:1];
        // sy*640 as sy*512 + sy*128
        addr_o = {sy, 9'd0} + {2'd0, sy, 7'd0} + {8'd0, sx};
        active_o = (hcount_i < 11'(H_ACTIVE)) && (vcount_i < 10'(V_ACTIVE));
        odd_o = hcount_i[0];
    end
endmodule

// File: rtl/fb_read_scheduler.sv
// fb_read_scheduler: shares the framebuffer BRAM port between scan-out reads and one writer.
module fb_read_scheduler import fb_pkg::*; (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [10:0]       hcount_in,
    input  logic [9:0]        vcount_in,
    input  logic              wr_valid_in,
    output logic              wr_ready_out,
    input  logic [ADDR_W-1:0] wr_addr_in,
    input  logic [PIX_W-1:0]  wr_data_in,
    output logic [ADDR_W-1:0] bram_addr_out,
    output logic              bram_we_out,
    output logic [PIX_W-1:0]  bram_din_out,
    input  logic [PIX_W-1:0]  bram_dout_in,
    output logic [PIX_W-1:0]  pixel_out,
    output logic              pixel_valid_out,
    output logic [7:0]        oob_count_out
);
    localparam int D = PIPE_L - 1;
    fb_sched_state_t state_q, state_d;
    logic [ADDR_W-1:0] rd_addr, addr_q, addr_d;
    logic [PIX_W-1:0] din_q, din_d, pix_q, pix_d;
    logic [7:0] oob_q, oob_d;
    logic [D-1:0] vsr_q, vsr_d, rsr_q, rsr_d;
    logic we_q, we_d, pval_q, pval_d;
    logic active, odd, run_now, rd_slot, xfer, in_range;
    fb_addr_gen u_addr (
        .hcount_i (hcount_in),
        .vcount_i (vcount_in),
        .addr_o   (rd_addr),
        .active_o (active),
        .odd_o    (odd)
    );
    always_comb begin
        // the (0,0) cycle that leaves SYNC already counts as a RUN read slot
        run_now = (state_q == RUN) || (hcount_in == '0 && vcount_in == '0);
        state_d = run_now ? RUN : SYNC;
        rd_slot = run_now && active && !odd;
        wr_ready_out = !rst_in && !rd_slot;
        xfer = wr_valid_in && wr_ready_out;
        in_range = wr_addr_in < ADDR_W'(SRC_DEPTH);
        addr_d = rd_slot ? rd_addr : (xfer && in_range) ? wr_addr_in : addr_q;
        we_d = !rd_slot && xfer && in_range;
        din_d = we_d ? wr_data_in : din_q;
        oob_d = (xfer && !in_range && oob_q != 8'hff) ? oob_q + 8'd1 : oob_q;
        vsr_d = {vsr_q[D-2:0], run_now && active};
        rsr_d = {rsr_q[D-2:0], rd_slot};
        pval_d = vsr_q[D-1];
        // odd active pixels repeat the value fetched for the even one
        pix_d = rsr_q[D-1] ? bram_dout_in : vsr_q[D-1] ? pix_q : '0;
    end
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= SYNC;
            addr_q <= '0;
            we_q <= 1'b0;
            din_q <= '0;
            oob_q <= '0;
            vsr_q <= '0;
            rsr_q <= '0;
            pval_q <= 1'b0;
            pix_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            we_q <= we_d;
            din_q <= din_d;
            oob_q <= oob_d;
            vsr_q <= vsr_d;
            rsr_q <= rsr_d;
            pval_q <= pval_d;
            pix_q <= pix_d;
        end
    end
    assign bram_addr_out = addr_q;
    assign bram_we_out = we_q;
    assign bram_din_out = din_q;
    assign oob_count_out = oob_q;
    assign pixel_out = pix_q;
    assign pixel_valid_out = pval_q;
endmodule

// File: tb/tb_fb_read_scheduler.sv
// tb_fb_read_scheduler: directed table, corner sequences and random writer traffic vs a reference model.
module tb_fb_read_scheduler;
    logic clk_in, rst_in, wr_valid_in, wr_ready_out, bram_we_out, pixel_valid_out;
    logic [10:0] hcount_in;
    logic [9:0] vcount_in;
    logic [17:0] wr_addr_in, bram_addr_out, b1, b2;
    logic [15:0] wr_data_in, bram_din_out, bram_dout_in, pixel_out;
    logic [7:0] oob_count_out;
    int errors = 0, checks = 0;
    logic m_run, m_we, last_ready, last_xfer;
    logic [17:0] m_addr;
    logic [15:0] m_din, prev_pix;
    int m_oob;
    logic hv[4];
    logic [15:0] hp[4];
    typedef struct {
        logic [10:0] h;
        logic [9:0] v;
        logic wv;
        logic [17:0] wa;
        logic [15:0] wd;
        logic ready;
        logic we;
        logic [17:0] addr;
    } vec_t;
    vec_t tbl[13];
    fb_read_scheduler dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .hcount_in       (hcount_in),
        .vcount_in       (vcount_in),
        .wr_valid_in     (wr_valid_in),
        .wr_ready_out    (wr_ready_out),
        .wr_addr_in      (wr_addr_in),
        .wr_data_in      (wr_data_in),
        .bram_addr_out   (bram_addr_out),
        .bram_we_out     (bram_we_out),
        .bram_din_out    (bram_din_out),
        .bram_dout_in    (bram_dout_in),
        .pixel_out       (pixel_out),
        .pixel_valid_out (pixel_valid_out),
        .oob_count_out   (oob_count_out)
    );
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;
    // BRAM stand-in: two-cycle latency, returns the low 16 address bits as data
    always @(posedge clk_in) begin
        b1 <= bram_addr_out;
        b2 <= b1;
    end
    assign bram_dout_in = b2[15:0];
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, a, e);
        end
    endtask
    task automatic model_reset();
        m_run = 0; m_we = 0; m_addr = 0; m_din = 0; m_oob = 0; prev_pix = 0;
        for (int i = 0; i < 4; i++) begin hv[i] = 0; hp[i] = 0; end
    endtask
    task automatic step(input logic [10:0] h, input logic [9:0] v, input logic wv,
                        input logic [17:0] wa, input logic [15:0] wd);
        logic run_now, act, rd, xfer;
        int src;
        hcount_in = h; vcount_in = v; wr_valid_in = wv; wr_addr_in = wa; wr_data_in = wd;
        #1;
        run_now = m_run || (h == 0 && v == 0);
        act = (h < 1280) && (v < 720);
        rd = run_now && act && !h[0];
        src = (int'(v) / 2) * 640 + int'(h) / 2;
        last_ready = wr_ready_out;
        chk("ready", wr_ready_out, !rd);
        xfer = wv && !rd;
        last_xfer = wv && wr_ready_out;
        if (rd) begin m_addr = 18'(src); m_we = 0; end
        else if (xfer && wa < 230400) begin m_addr = wa; m_din = wd; m_we = 1; end
        else m_we = 0;
        if (xfer && wa >= 230400 && m_oob < 255) m_oob++;
        for (int i = 3; i > 0; i--) begin hv[i] = hv[i-1]; hp[i] = hp[i-1]; end
        hv[0] = run_now && act;
        hp[0] = !hv[0] ? 16'd0 : !h[0] ? 16'(src) : prev_pix;
        prev_pix = hp[0];
        m_run = run_now;
        @(posedge clk_in); #1;
        chk("addr", bram_addr_out, m_addr);
        chk("we", bram_we_out, m_we);
        chk("din", bram_din_out, m_din);
        chk("oob", oob_count_out, m_oob);
        chk("pvalid", pixel_valid_out, hv[3]);
        chk("pixel", pixel_out, hp[3]);
    endtask
    task automatic chk_zero(input string n);
        chk({n, "_addr"}, bram_addr_out, 0);
        chk({n, "_we"}, bram_we_out, 0);
        chk({n, "_din"}, bram_din_out, 0);
        chk({n, "_pix"}, pixel_out, 0);
        chk({n, "_pvalid"}, pixel_valid_out, 0);
        chk({n, "_oob"}, oob_count_out, 0);
        chk({n, "_ready"}, wr_ready_out, 0);
    endtask
    initial begin
        int cnt, h, v, k;
        logic seen, wv;
        logic [17:0] wa;
        logic [15:0] wd;
        tbl[0]  = '{11'd5,    10'd3,   1'b0, 18'd0,      16'h0000, 1'b1, 1'b0, 18'd0};
        tbl[1]  = '{11'd6,    10'd3,   1'b1, 18'd7,      16'h1111, 1'b1, 1'b1, 18'd7};
        tbl[2]  = '{11'd0,    10'd0,   1'b0, 18'd0,      16'h0000, 1'b0, 1'b0, 18'd0};
        tbl[3]  = '{11'd1,    10'd0,   1'b0, 18'd0,      16'h0000, 1'b1, 1'b0, 18'd0};
        tbl[4]  = '{11'd2,    10'd0,   1'b0, 18'd0,      16'h0000, 1'b0, 1'b0, 18'd1};
        tbl[5]  = '{11'd20,   10'd3,   1'b1, 18'd100,    16'hABCD, 1'b0, 1'b0, 18'd650};
        tbl[6]  = '{11'd21,   10'd3,   1'b1, 18'd100,    16'hABCD, 1'b1, 1'b1, 18'd100};
        tbl[7]  = '{11'd22,   10'd3,   1'b0, 18'd0,      16'h0000, 1'b0, 1'b0, 18'd651};
        tbl[8]  = '{11'd1280, 10'd3,   1'b1, 18'd230400, 16'h7777, 1'b1, 1'b0, 18'd651};
        tbl[9]  = '{11'd1279, 10'd719, 1'b0, 18'd0,      16'h0000, 1'b1, 1'b0, 18'd651};
        tbl[10] = '{11'd1278, 10'd719, 1'b0, 18'd0,      16'h0000, 1'b0, 1'b0, 18'd230399};
        tbl[11] = '{11'd1280, 10'd720, 1'b1, 18'd5,      16'h5555, 1'b1, 1'b1, 18'd5};
        tbl[12] = '{11'd0,    10'd720, 1'b0, 18'd0,      16'h0000, 1'b1, 1'b0, 18'd5};
        rst_in = 1; hcount_in = 0; vcount_in = 0; wr_valid_in = 0; wr_addr_in = 0; wr_data_in = 0;
        #1;
        chk_zero("rst");
        @(posedge clk_in); @(posedge clk_in); #1;
        rst_in = 0;
        model_reset();
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].h, tbl[i].v, tbl[i].wv, tbl[i].wa, tbl[i].wd);
            chk("tbl_ready", last_ready, tbl[i].ready);
            chk("tbl_we", bram_we_out, tbl[i].we);
            chk("tbl_addr", bram_addr_out, tbl[i].addr);
        end
        for (int x = 16; x <= 30; x++) begin
            step(11'(x), 10'd3, 1'b0, 18'd0, 16'd0);
            if (x == 23 || x == 24) begin
                chk("scan_pix", pixel_out, 650);
                chk("scan_valid", pixel_valid_out, 1);
            end
        end
        cnt = 0;
        for (int x = 1280; x < 1650; x++) begin
            step(11'(x), 10'd100, 1'b1, 18'(x - 280), 16'($urandom));
            cnt += int'(bram_we_out);
        end
        chk("blank_we_pulses", cnt, 370);
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            step(11'(i), 10'd730, 1'b1, 18'd230400, 16'(i));
            seen |= bram_we_out;
        end
        chk("oob_we", seen, 0);
        chk("oob_sat", oob_count_out, 255);
        h = 1640; v = $urandom_range(0, 700); wv = 0; wa = 0; wd = 0; last_xfer = 0;
        for (int n = 0; n < 4000; n++) begin
            if (!wv || last_xfer) begin
                wv = $urandom_range(0, 3) != 0;
                wa = ($urandom_range(0, 15) == 0) ? 18'(230400 + $urandom_range(0, 100))
                                                  : 18'($urandom_range(0, 230399));
                wd = 16'($urandom);
            end
            step(11'(h), 10'(v), wv, wa, wd);
            h++;
            if (h == 1650) begin h = 0; v = (v + 1) % 750; end
        end
        for (int x = 590; x < 600; x++) step(11'(x), 10'd10, 1'b0, 18'd0, 16'd0);
        hcount_in = 600; vcount_in = 10;
        #2 rst_in = 1;
        #1;
        chk_zero("midrst");
        model_reset();
        @(posedge clk_in); #1;
        chk_zero("midrst_hold");
        rst_in = 0;
        seen = 0;
        for (int x = 602; x < 620; x++) begin
            step(11'(x), 10'd10, 1'b0, 18'd0, 16'd0);
            seen |= pixel_valid_out;
        end
        for (int x = 1645; x < 1650; x++) begin
            step(11'(x), 10'd749, 1'b0, 18'd0, 16'd0);
            seen |= pixel_valid_out;
        end
        for (k = 0; k < 8; k++) begin
            step(11'(k), 10'd0, 1'b0, 18'd0, 16'd0);
            if (k < 3) seen |= pixel_valid_out;
            if (k == 3) chk("resync_valid", pixel_valid_out, 1);
        end
        chk("rst_novalid", seen, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fb_read_scheduler.md
Name: fb_read_scheduler

Overview:
- Time-shares the single port of the 640x360 framebuffer BRAM between the HDMI scan-out reader and one pixel-writer client.
- Reads are driven by video timing counts (hcount/vcount, 1280x720 active) and halved in both axes; one BRAM read serves two adjacent output pixels.
- The spare slots (odd active cycles, all blanking cycles) are granted to the writer through a valid/ready handshake.
- Sits between the video signal generator, the framebuffer BRAM and the renderer/camera write path.

Parameters:
- H_ACTIVE, 1280, active output pixels per line
- V_ACTIVE, 720, active output lines
- SRC_W, 640, framebuffer row width (H_ACTIVE/2)
- SRC_DEPTH, 230400, framebuffer entries (SRC_W*V_ACTIVE/2)
- ADDR_W, 18, BRAM address width
- PIX_W, 16, pixel width (RGB565)
- BRAM_LATENCY, 2, BRAM read latency in cycles (address registered to dout valid)

Ports:
- clk_in  in  1  pixel clock (74.25 MHz)
- rst_in  in  1  reset, asynchronous, active-high
- hcount_in  in  11  horizontal count from the video timing generator
- vcount_in  in  10  vertical count from the video timing generator
- wr_valid_in  in  1  writer has a pixel
- wr_ready_out  out  1  scheduler accepts the write this cycle
- wr_addr_in  in  ADDR_W  framebuffer write address
- wr_data_in  in  PIX_W  write pixel
- bram_addr_out  out  ADDR_W  BRAM port address (registered)
- bram_we_out  out  1  BRAM write enable (registered)
- bram_din_out  out  PIX_W  BRAM write data (registered)
- bram_dout_in  in  PIX_W  BRAM read data
- pixel_out  out  PIX_W  scan-out pixel
- pixel_valid_out  out  1  pixel_out corresponds to an active pixel
- oob_count_out  out  8  saturating count of discarded out-of-range writes

Behaviour:
- Reset behaviour (asynchronous assert):
  - FSM goes to SYNC.
  - All outputs are 0: bram_addr_out, bram_we_out, bram_din_out, pixel_out, pixel_valid_out, oob_count_out, wr_ready_out.
  - The read pipeline is flushed.
- Active region: hcount_in < H_ACTIVE and vcount_in < V_ACTIVE.
- FSM, SYNC state:
  - No reads are issued and pixel_valid_out = 0.
  - Every cycle is a write slot.
  - Go to RUN on the cycle where hcount_in==0 and vcount_in==0. That cycle is already treated as a RUN read slot.
- FSM, RUN state:
  - Stay in RUN until reset. There is no other exit.
- Slot rule in RUN:
  - Read slot: active region and hcount_in[0]==0.
  - Write slot: all other cycles.
- wr_ready_out:
  - Combinational from the current slot: 1 in a write slot, else 0.
  - Forced to 0 while rst_in is high.
  - Transfer occurs when wr_valid_in && wr_ready_out.
  - The writer may hold wr_valid_in across read slots. The data must stay stable until the transfer.
- Read address:
  - Computed from sx = hcount_in>>1 and sy = vcount_in>>1.
  - addr = (sy<<9) + (sy<<7) + sx, which equals sy*640 + sx. Use no multiplier; the maximum value 230399 fits ADDR_W.
  - Registered into bram_addr_out on the next clock edge, with bram_we_out=0.
- Write transfer:
  - On the next edge, load bram_addr_out=wr_addr_in, bram_din_out=wr_data_in and bram_we_out=1.
- Out-of-range writes (wr_addr_in >= SRC_DEPTH):
  - The write is still accepted (handshake completes) but bram_we_out stays 0.
  - oob_count_out increments and saturates at 255.
- Idle cycles: write slot with no transfer gives bram_we_out=0; bram_addr_out holds its value.
- Scan-out latency:
  - Total latency from hcount_in to pixel output is L = BRAM_LATENCY+2 cycles.
  - A read issued for hcount_in=h (even) produces pixel_out=bram_dout_in and pixel_valid_out=1 L cycles after h is presented.
  - The value is held for the following cycle (h+1), so each source pixel appears twice.
  - Outside the active region, pixel_out=0 and pixel_valid_out=0, aligned with the same L-cycle latency. This uses a valid/parity shift register of depth L.
- Vertical doubling: lines 2k and 2k+1 read the same source row. There is no line buffer.
- Writes and reads never share a cycle, so no read/write hazard exists on the port. Coherence between frames is the writer's responsibility.
- Reset mid-frame:
  - Returns the block to SYNC, the pipeline is discarded, and pixel_valid_out drops immediately.
  - No reads are issued until the next (0,0).

Decomposition:
- Shared package fb_pkg: H_ACTIVE, V_ACTIVE, SRC_W, SRC_DEPTH, ADDR_W, PIX_W, and the state enum typedef (SYNC, RUN) as fb_sched_state_t.
- One sub-module, fb_addr_gen: combinational (hcount, vcount) to source address plus active/parity flags.

Test Plan:
- Reset then counts starting at (hcount=5, vcount=3): no reads and wr_ready_out=1 until (0,0). At (0,0), wr_ready_out=0 and bram_addr_out=0 on the next cycle.
- Active scan at vcount=3, hcount=20 (BRAM returns addr as data): bram_addr_out=650. pixel_out=650 with valid at hcount+4 for h=20 and h=21.
- wr_valid_in held with addr=100, data=0xABCD starting at an even active hcount: no transfer until the odd cycle. The next edge gives bram_we_out=1, addr=100, din=0xABCD.
- Writes streamed during blanking (hcount 1280..1649): a transfer every cycle, 370 consecutive bram_we_out pulses.
- Write to addr 230400 repeated 300 times: bram_we_out never 1 and oob_count_out saturates at 255.
- rst_in pulsed at hcount=600 mid-frame: outputs 0 asynchronously, and pixel_valid_out stays 0 until (0,0)+4 cycles.
